data_memory: RTL and testbench

DATA_MEMORY -- requirements
Module: data_memory

---
 rtl/data_memory_pkg.sv | 16 +
 rtl/data_memory.sv | 47 ++++
 tb/tb_data_memory.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/data_memory_pkg.sv
// Shared CPU package: word width and default memory depth.
// The instruction and data memories both use these constants.
package data_memory_pkg;

   // Width of one memory word in bits
   localparam int DATA_W    = 32;

   // Default number of words in each memory
   localparam int MEM_DEPTH = 1024;

   // Converts a byte address into a word index, wrapping every depth words
   function automatic int wordIndexOf(input logic [31:0] byteAddr, input int depth);
      return int'((byteAddr >> 2) % depth);
   endfunction

endpackage

// File: rtl/data_memory.sv
// Data memory: DEPTH x 32-bit words, synchronous write and clear,
// combinational read. Addresses are byte addresses. The two lowest
// address bits are ignored, and bits above the word index are ignored,
// so any address that is not word-aligned, or that is beyond the
// array, wraps onto a word.
module data_memory
   import data_memory_pkg::*;
#(
   parameter int DEPTH = MEM_DEPTH,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic [31:0]       Address,
   input  logic [DATA_W-1:0] WriteData,
   input  logic              MemWrite,
   input  logic              MemRead,
   output logic [DATA_W-1:0] ReadData
);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [AW-1:0]     wordIndex;
   logic              unusedAddrBits;

   assign wordIndex      = Address[AW+1:2];
   assign unusedAddrBits = ^{Address[31:AW+2], Address[1:0]};

   // Clear every word on reset, otherwise store WriteData when MemWrite is high
   always_ff @(posedge Clk) begin
      if (Reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (MemWrite) begin
         mem[wordIndex] <= WriteData;
      end
   end

   // Drive the addressed word onto ReadData when MemRead is high, otherwise drive zero
   always_comb begin
      ReadData = '0;
      if (MemRead) begin
         ReadData = mem[wordIndex];
      end
   end

endmodule

// File: tb/tb_data_memory.sv
// Self-checking bench for data_memory: directed scenarios plus
// randomized accesses compared against a behavioural word-array model.
module tb_data_memory;

   localparam int DEPTH = 1024;
   localparam int AW    = 10;

   logic        Clk;
   logic        Reset;
   logic [31:0] Address;
   logic [31:0] WriteData;
   logic        MemWrite;
   logic        MemRead;
   logic [31:0] ReadData;

   int total = 0;
   int bad   = 0;

   logic [31:0] model [DEPTH];

   data_memory #(.DEPTH(DEPTH), .AW(AW)) dut (
      .Clk       (Clk),
      .Reset     (Reset),
      .Address   (Address),
      .WriteData (WriteData),
      .MemWrite  (MemWrite),
      .MemRead   (MemRead),
      .ReadData  (ReadData)
   );

   // Free-running clock with a 10 ns period
   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end

   task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] modelRead(input logic rd, input logic [31:0] addr);
      if (!rd) return 32'h0;
      return model[(addr / 4) % DEPTH];
   endfunction

   // One clock cycle: drive at the falling edge, check the read before and after the rising edge
   task automatic doCycle(input string tag, input logic rst, input logic wr, input logic rd,
                          input logic [31:0] addr, input logic [31:0] data);
      @(negedge Clk);
      Reset = rst; MemWrite = wr; MemRead = rd; Address = addr; WriteData = data;
      #1 checkEq({tag, "_pre"}, ReadData, modelRead(rd, addr));
      @(posedge Clk);
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) model[i] = 32'h0;
      end else if (wr) begin
         model[(addr / 4) % DEPTH] = data;
      end
      #1 checkEq({tag, "_post"}, ReadData, modelRead(rd, addr));
   endtask

   // Combinational read with no clock edge involved
   task automatic peek(input string tag, input logic rd, input logic [31:0] addr);
      Reset = 1'b0; MemWrite = 1'b0; MemRead = rd; Address = addr;
      #1 checkEq(tag, ReadData, modelRead(rd, addr));
   endtask

   initial begin
      logic [31:0] a;
      logic [31:0] d;
      int          r;

      Reset = 1'b0; MemWrite = 1'b0; MemRead = 1'b0; Address = '0; WriteData = '0;
      for (int i = 0; i < DEPTH; i++) model[i] = 32'h0;

      // Reset clears the array; both ends read zero
      doCycle("reset", 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
      @(negedge Clk);
      peek("rst_addr0", 1'b1, 32'h0);
      checkEq("rst_addr0_lit", ReadData, 32'h0);
      peek("rst_addrFFC", 1'b1, 32'hFFC);
      checkEq("rst_addrFFC_lit", ReadData, 32'h0);

      // Basic write then read
      doCycle("wr0", 1'b0, 1'b1, 1'b0, 32'h0, 32'd4);
      @(negedge Clk);
      peek("rd0", 1'b1, 32'h0);
      checkEq("rd0_lit", ReadData, 32'd4);

      // Second word, MemRead gating, first word untouched
      doCycle("wr4", 1'b0, 1'b1, 1'b0, 32'h4, 32'd7);
      @(negedge Clk);
      peek("rd4", 1'b1, 32'h4);
      checkEq("rd4_lit", ReadData, 32'd7);
      peek("rd4_off", 1'b0, 32'h4);
      checkEq("rd4_off_lit", ReadData, 32'h0);
      peek("rd0_again", 1'b1, 32'h0);
      checkEq("rd0_again_lit", ReadData, 32'd4);

      // Alias and ignored low bits
      doCycle("wr1003", 1'b0, 1'b1, 1'b0, 32'h1003, 32'hDEAD_BEEF);
      @(negedge Clk);
      peek("rd_alias", 1'b1, 32'h0);
      checkEq("rd_alias_lit", ReadData, 32'hDEAD_BEEF);

      // Simultaneous read and write: old value before the edge, new value after
      doCycle("rdwr8", 1'b0, 1'b1, 1'b1, 32'h8, 32'd5);
      @(negedge Clk);
      peek("rd8", 1'b1, 32'h8);
      checkEq("rd8_lit", ReadData, 32'd5);

      // Reset between edges has no effect on contents
      @(negedge Clk);
      Reset = 1'b1;
      #2 Reset = 1'b0;
      @(posedge Clk);
      #1 peek("async_rst", 1'b1, 32'h4);
      checkEq("async_rst_lit", ReadData, 32'd7);

      // Reset wins over a write on the same edge
      doCycle("rst_wr", 1'b1, 1'b1, 1'b0, 32'h0, 32'd9);
      @(negedge Clk);
      peek("rst_wr_rd", 1'b1, 32'h0);
      checkEq("rst_wr_rd_lit", ReadData, 32'h0);

      // Randomized accesses over a narrow window of words, so addresses collide often
      for (int n = 0; n < 400; n++) begin
         a = $urandom;
         if ($urandom_range(0, 3) != 0) a = a & 32'hFFFF_F03F;
         d = $urandom;
         r = $urandom_range(0, 99);
         doCycle("rand", (r == 0), ($urandom_range(0, 1) == 1), ($urandom_range(0, 3) != 0), a, d);
      end

      // Sweep of pure reads with no clock edge between them
      @(negedge Clk);
      for (int n = 0; n < 50; n++) begin
         a = $urandom & 32'hFFFF_F03F;
         peek("sweep", ($urandom_range(0, 3) != 0), a);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
